md_unit_ex: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage of the pipelined RISC-V core, directly downstream of the ID/EX pipeline register. It consumes the ID/EX instruction word and the post-forwarding operands. When an M-extension instruction occupies EX, it raises a stall request, runs a 32-iteration shift-based datapath, and presents the 32-bit result for one cycle. That result feeds the EX result mux alongside the ALU output.

---
 rtl/md_pkg.sv | 24 ++
 rtl/md_shift_core.sv | 73 +++++++
 rtl/md_unit_ex.sv | 140 ++++++++++++++
 tb/tb_md_unit_ex.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared types and decode constants for the RV32M multiply/divide unit.
package md_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_DONE
  } md_state_t;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/md_shift_core.sv
// Shared iterative datapath: radix-2 shift-add multiply or restoring divide on
// unsigned magnitudes, one bit per cycle for XLEN cycles.
module md_shift_core
  import md_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   mag_a_i,
  input  logic [XLEN-1:0]   mag_b_i,
  output logic              busy_o,
  output logic [2*XLEN-1:0] raw_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q;
  logic [CW-1:0]     cnt_q;
  logic              active_q, is_div_q;

  logic [XLEN-1:0] hi, lo;
  logic [XLEN:0]   rem_sh, op_a, op_b;
  logic [XLEN+1:0] sum;

  assign hi = acc_q[2*XLEN-1:XLEN];
  assign lo = acc_q[XLEN-1:0];

  // One adder serves both ops: add multiplicand, or subtract divisor via ~b + 1.
  // For divide, sum[XLEN+1] is the carry out, i.e. "partial remainder >= divisor".
  always_comb begin
    rem_sh = {hi, lo[XLEN-1]};
    op_a   = is_div_q ? rem_sh : {1'b0, hi};
    op_b   = is_div_q ? ~{1'b0, b_q} : {1'b0, b_q};
    sum    = {1'b0, op_a} + {1'b0, op_b} + {{(XLEN+1){1'b0}}, is_div_q};
    if (is_div_q) begin
      if (sum[XLEN+1]) acc_d = {sum[XLEN-1:0], lo[XLEN-2:0], 1'b1};
      else             acc_d = {rem_sh[XLEN-1:0], lo[XLEN-2:0], 1'b0};
    end else begin
      if (lo[0]) acc_d = {sum[XLEN:0], lo[XLEN-1:1]};
      else       acc_d = {1'b0, hi, lo[XLEN-1:1]};
    end
  end

  // raw_o is the post-step value, so it is final during the last iteration.
  assign raw_o  = acc_d;
  assign busy_o = active_q && (cnt_q != LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      is_div_q <= 1'b0;
    end else if (start_i) begin
      acc_q    <= {{XLEN{1'b0}}, mag_a_i};
      b_q      <= mag_b_i;
      cnt_q    <= '0;
      active_q <= 1'b1;
      is_div_q <= is_div_i;
    end else if (active_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/md_unit_ex.sv
// EX-stage RV32M unit: decode, sign handling, special cases, flush and the
// IDLE/RUN/DONE sequencer around the shared shift core.
module md_unit_ex
  import md_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     INSTR_EX,
  input  logic [XLEN-1:0] DATA1_EX,
  input  logic [XLEN-1:0] DATA2_EX,
  input  logic            FLUSH_MD,
  output logic            MD_STALL,
  output logic            MD_VALID,
  output logic [XLEN-1:0] MD_RESULT_EX
);

  md_state_t       state_q, state_d;
  logic [2:0]      f3_q;
  logic            neg_q;
  logic [XLEN-1:0] result_q, result_d;

  logic [2:0] funct3;
  logic       is_mop, a_signed, b_signed, neg_a, neg_b, res_neg;
  logic       div_zero, div_ovf;
  logic       unused_instr_fields;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  assign funct3 = INSTR_EX[14:12];
  assign is_mop = (INSTR_EX[6:0] == OPCODE_OP) && (INSTR_EX[31:25] == FUNCT7_MULDIV);
  assign unused_instr_fields = ^{INSTR_EX[24:15], INSTR_EX[11:7]};

  assign a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                    (funct3 == F3_DIV)  || (funct3 == F3_REM);
  assign b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign neg_a    = a_signed && DATA1_EX[XLEN-1];
  assign neg_b    = b_signed && DATA2_EX[XLEN-1];
  assign mag_a    = neg_a ? -DATA1_EX : DATA1_EX;
  assign mag_b    = neg_b ? -DATA2_EX : DATA2_EX;
  // Remainders follow the dividend's sign; products and quotients the XOR.
  assign res_neg  = (funct3 == F3_REM) ? neg_a : (neg_a ^ neg_b);

  assign div_zero = funct3[2] && (DATA2_EX == '0);
  assign div_ovf  = (funct3 == F3_DIV || funct3 == F3_REM) &&
                    (DATA1_EX == {1'b1, {(XLEN-1){1'b0}}}) && (DATA2_EX == '1);
  assign special_res = funct3[1] ? (div_zero ? DATA1_EX : '0)
                                 : (div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}});

  logic              core_start, core_busy;
  logic [2*XLEN-1:0] core_raw;

  md_shift_core u_core (
    .clk      (clk),
    .rst_n    (rst),
    .start_i  (core_start),
    .is_div_i (funct3[2]),
    .mag_a_i  (mag_a),
    .mag_b_i  (mag_b),
    .busy_o   (core_busy),
    .raw_o    (core_raw)
  );

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, post_res;

  always_comb begin
    prod_fix = neg_q ? -core_raw : core_raw;
    quot_fix = neg_q ? -core_raw[XLEN-1:0] : core_raw[XLEN-1:0];
    rem_fix  = neg_q ? -core_raw[2*XLEN-1:XLEN] : core_raw[2*XLEN-1:XLEN];
    case (f3_q)
      F3_MUL:                       post_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: post_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              post_res = quot_fix;
      default:                      post_res = rem_fix;
    endcase
  end

  logic stall, valid;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    stall      = 1'b0;
    valid      = 1'b0;
    core_start = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (is_mop) begin
          stall = 1'b1;
          if (!FLUSH_MD) begin
            if (div_zero || div_ovf) begin
              result_d = special_res;
              state_d  = MD_DONE;
            end else begin
              core_start = 1'b1;
              state_d    = MD_RUN;
            end
          end
        end
      end
      MD_RUN: begin
        stall = 1'b1;
        if (FLUSH_MD) begin
          state_d = MD_IDLE;
        end else if (!core_busy) begin
          result_d = post_res;
          state_d  = MD_DONE;
        end
      end
      MD_DONE: begin
        valid   = !FLUSH_MD;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // The IDLE stall is combinational from INSTR_EX; masking it with reset keeps
  // every output low for the whole time reset is held.
  assign MD_STALL     = stall && rst;
  assign MD_VALID     = valid;
  assign MD_RESULT_EX = result_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= MD_IDLE;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (core_start) begin
        f3_q  <= funct3;
        neg_q <= res_neg;
      end
    end
  end

endmodule

// File: tb/tb_md_unit_ex.sv
// Self-checking bench for md_unit_ex: a per-cycle expectation queue filled from
// an arithmetic reference model, drained by a single compare process.
module tb_md_unit_ex;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] INSTR_EX, DATA1_EX, DATA2_EX;
  logic        FLUSH_MD;
  logic        MD_STALL, MD_VALID;
  logic [31:0] MD_RESULT_EX;

  md_unit_ex dut (
    .clk          (clk),
    .rst          (rst),
    .INSTR_EX     (INSTR_EX),
    .DATA1_EX     (DATA1_EX),
    .DATA2_EX     (DATA2_EX),
    .FLUSH_MD     (FLUSH_MD),
    .MD_STALL     (MD_STALL),
    .MD_VALID     (MD_VALID),
    .MD_RESULT_EX (MD_RESULT_EX)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic        stall;
    logic        valid;
    logic [31:0] res;
  } exp_t;

  exp_t exp_q[$];
  int   valid_cyc[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  bit   chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  // Reference: plain 64-bit arithmetic plus the architectural special cases.
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f3)
      F3_MUL:    begin p = ua * ub;            return p[31:0];  end
      F3_MULH:   begin p = sa * sb;            return p[63:32]; end
      F3_MULHSU: begin p = sa * longint'(ub);  return p[63:32]; end
      F3_MULHU:  begin p = ua * ub;            return p[63:32]; end
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      F3_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      F3_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Single compare process: one expectation per cycle, idle when queue is empty.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      check("MD_STALL", {31'd0, MD_STALL}, {31'd0, e.stall});
      check("MD_VALID", {31'd0, MD_VALID}, {31'd0, e.valid});
      if (e.valid) check("MD_RESULT_EX", MD_RESULT_EX, e.res);
      if (MD_VALID) valid_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; occupies EX until the unit releases it.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int   n;
    exp_t e;
    INSTR_EX = mk_instr(FUNCT7_MULDIV, f3, OPCODE_OP);
    DATA1_EX = a;
    DATA2_EX = b;
    n = is_special(f3, a, b) ? 1 : 33;
    e = '{stall: 1'b1, valid: 1'b0, res: 32'd0};
    for (int i = 0; i < n; i++) exp_q.push_back(e);
    e = '{stall: 1'b0, valid: 1'b1, res: ref_md(f3, a, b)};
    exp_q.push_back(e);
    repeat (n + 1) step();
    INSTR_EX = NOP;
  endtask

  task automatic pin(input string name, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] lit);
    check(name, ref_md(f3, a, b), lit);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ins;
    INSTR_EX = mk_instr(FUNCT7_MULDIV, F3_MUL, OPCODE_OP);
    DATA1_EX = 32'd7;
    DATA2_EX = 32'd3;
    FLUSH_MD = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_stall",  {31'd0, MD_STALL}, 32'd0);
    check("reset_valid",  {31'd0, MD_VALID}, 32'd0);
    check("reset_result", MD_RESULT_EX, 32'd0);
    INSTR_EX = NOP;
    step();
    rst    = 1'b1;
    chk_en = 1'b1;
    repeat (2) step();

    pin("pin_mul",    F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    pin("pin_mulh",   F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
    pin("pin_mulhu",  F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    pin("pin_mulhsu", F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    pin("pin_div",    F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
    pin("pin_rem",    F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
    pin("pin_divu",   F3_DIVU,   32'd100,        32'd7,         32'd14);
    pin("pin_remu",   F3_REMU,   32'd100,        32'd7,         32'd2);
    pin("pin_divu0",  F3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF);
    pin("pin_remu0",  F3_REMU,   32'd5,          32'd0,         32'd5);
    pin("pin_divovf", F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    pin("pin_removf", F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0);

    issue(F3_MUL,    32'd7,         32'hFFFF_FFFD);
    issue(F3_MULH,   32'h8000_0000, 32'h8000_0000);
    issue(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(F3_DIV,    32'hFFFF_FFF9, 32'd2);
    issue(F3_REM,    32'hFFFF_FFF9, 32'd2);
    issue(F3_DIVU,   32'd100,       32'd7);
    issue(F3_REMU,   32'd100,       32'd7);
    issue(F3_DIVU,   32'd5,         32'd0);
    issue(F3_REMU,   32'd5,         32'd0);
    issue(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF);
    issue(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF);

    // Back-to-back MUL then DIV: DONE pulses 34 cycles apart.
    valid_cyc.delete();
    issue(F3_MUL, 32'd12345, 32'd678);
    issue(F3_DIV, 32'hFFFF_0000, 32'd17);
    check("b2b_pulses", valid_cyc.size(), 32'd2);
    if (valid_cyc.size() == 2) check("b2b_spacing", valid_cyc[1] - valid_cyc[0], 32'd34);

    // ADD and an OP-IMM word with funct7-like bits set must never stall.
    issue(F3_MUL, 32'hDEAD_BEEF, 32'h1234_5678);
    INSTR_EX = mk_instr(7'b0000000, 3'b000, OPCODE_OP);
    step();
    INSTR_EX = mk_instr(FUNCT7_MULDIV, 3'b000, 7'b0010011);
    step();
    issue(F3_DIVU, 32'hDEAD_BEEF, 32'h1234);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        ins = $urandom;
        if (ins[6:0] == OPCODE_OP && ins[31:25] == FUNCT7_MULDIV) ins[25] = 1'b0;
        INSTR_EX = ins;
        DATA1_EX = $urandom;
        DATA2_EX = $urandom;
        step();
      end else begin
        issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand());
      end
    end
    INSTR_EX = NOP;

    // Flush during RUN cycle 5: stall drops next cycle, no DONE pulse.
    valid_cyc.delete();
    INSTR_EX = mk_instr(FUNCT7_MULDIV, F3_DIVU, OPCODE_OP);
    DATA1_EX = 32'd1000;
    DATA2_EX = 32'd3;
    for (int i = 0; i < 6; i++) exp_q.push_back('{stall: 1'b1, valid: 1'b0, res: 32'd0});
    repeat (5) step();
    FLUSH_MD = 1'b1;
    INSTR_EX = NOP;
    step();
    FLUSH_MD = 1'b0;
    repeat (40) step();
    check("flush_no_valid", valid_cyc.size(), 32'd0);

    // Leave a nonzero result behind, then reset in the middle of RUN.
    issue(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_en   = 1'b0;
    INSTR_EX = mk_instr(FUNCT7_MULDIV, F3_MUL, OPCODE_OP);
    DATA1_EX = 32'd7;
    DATA2_EX = 32'hFFFF_FFFD;
    repeat (10) step();
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_stall",  {31'd0, MD_STALL}, 32'd0);
    check("rst_mid_valid",  {31'd0, MD_VALID}, 32'd0);
    check("rst_mid_result", MD_RESULT_EX, 32'd0);
    check("rst_mid_state",  32'(dut.state_q), 32'(MD_IDLE));
    INSTR_EX = NOP;
    step();
    rst    = 1'b1;
    chk_en = 1'b1;
    repeat (40) step();
    issue(F3_MUL, 32'd7, 32'hFFFF_FFFD);
    repeat (3) step();

    chk_en = 1'b0;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
